// File: rtl/mem_arbiter.sv
// Arbiter sharing one line-burst memory port between I-cache refill and D-cache refill/writeback.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise D-side wins ties.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    output logic              ic_resp_last,
    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic              dc_wdata_valid,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic              dc_resp_last,
    output logic              dc_wr_done,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              owner,
    output logic              busy,
    output logic              err_unexp
);

    localparam int CNT_W      = $clog2(LINE_BEATS);
    localparam int LINE_BYTES = LINE_BEATS * DATA_W / 8;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    // state  | meaning
    // IDLE   | arbitrate, grant at most one requester
    // CMD    | present line command to memory
    // WDATA  | stream D-side write beats to memory
    // RDATA  | capture read beats, forward to owner one cycle later
    // DONE   | one-cycle completion, write-done pulse, counter clear
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                ic_rv_q, ic_rv_d;
    logic                dc_rv_q, dc_rv_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic                pick_dc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            ic_rv_q     <= 1'b0;
            dc_rv_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            ic_rv_q     <= ic_rv_d;
            dc_rv_q     <= dc_rv_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign pick_dc = dc_req_valid && (!ic_req_valid || !owner_q);
`else
    assign pick_dc = dc_req_valid;
`endif

    always_comb begin
        state_d         = state_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        owner_d         = owner_q;
        cnt_d           = cnt_q;
        resp_data_d     = resp_data_q;
        ic_rv_d         = 1'b0;
        dc_rv_d         = 1'b0;
        last_d          = 1'b0;
        err_d           = err_q | (mem_resp_valid && (state_q != S_RDATA));
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_rw      = 1'b0;
        mem_req_addr    = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        dc_wdata_ready  = 1'b0;
        dc_wr_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_dc) begin
                    dc_req_ready = 1'b1;
                    rw_d         = dc_req_rw;
                    addr_d       = dc_req_addr;
                    owner_d      = 1'b1;
                    state_d      = S_CMD;
                end else if (ic_req_valid) begin
                    ic_req_ready = 1'b1;
                    rw_d         = 1'b0;
                    addr_d       = ic_req_addr;
                    owner_d      = 1'b0;
                    state_d      = S_CMD;
                end
            end
            S_CMD: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = rw_q;
                mem_req_addr  = addr_q & LINE_MASK;
                if (mem_req_ready) begin
                    state_d = rw_q ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                mem_wdata_valid = dc_wdata_valid;
                mem_wdata       = dc_wdata;
                dc_wdata_ready  = mem_wdata_ready;
                if (dc_wdata_valid && mem_wdata_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RDATA: begin
                if (mem_resp_valid) begin
                    resp_data_d = mem_resp_data;
                    ic_rv_d     = !owner_q;
                    dc_rv_d     = owner_q;
                    last_d      = (cnt_q == LAST_BEAT);
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                dc_wr_done = rw_q;
                cnt_d      = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ic_resp_valid = ic_rv_q;
    assign dc_resp_valid = dc_rv_q;
    assign ic_resp_last  = ic_rv_q & last_q;
    assign dc_resp_last  = dc_rv_q & last_q;
    assign resp_data     = resp_data_q;
    assign owner         = owner_q;
    assign busy          = (state_q != S_IDLE);
    assign err_unexp     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives both requesters and a memory model, scoreboards beats.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LB = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_resp_valid, ic_resp_last;
    logic [AW-1:0] ic_req_addr;
    logic          dc_req_valid, dc_req_rw, dc_req_ready;
    logic [AW-1:0] dc_req_addr;
    logic          dc_wdata_valid, dc_wdata_ready, dc_resp_valid, dc_resp_last, dc_wr_done;
    logic [DW-1:0] dc_wdata, resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_wdata_valid, mem_wdata_ready;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          owner, busy, err_unexp;

    int n_checks = 0;
    int n_err    = 0;
    logic [DW:0]   rd_q[$];
    logic [DW-1:0] wr_q[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
        .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_last(dc_resp_last),
        .dc_wr_done(dc_wr_done), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .owner(owner), .busy(busy), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_phase(input logic [AW-1:0] exp_addr, input logic exp_rw);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_req_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("cmd_seen", 64'(ok), 64'd1);
        check("cmd_addr", 64'(mem_req_addr), 64'(exp_addr));
        check("cmd_rw", 64'(mem_req_rw), 64'(exp_rw));
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
    endtask

    task automatic read_beats(input bit to_dc, input logic [DW-1:0] base, input int n);
        logic [DW:0] exp_beat;
        for (int i = 0; i < n; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + DW'(i);
            rd_q.push_back({(i == LB - 1), base + DW'(i)});
            step();
            mem_resp_valid = 1'b0;
            #1;
            check("rsp_side", 64'({ic_resp_valid, dc_resp_valid}), to_dc ? 64'd1 : 64'd2);
            if (rd_q.size() == 0) begin
                check("rsp_queue_empty", 64'd0, 64'd1);
            end else begin
                exp_beat = rd_q.pop_front();
                check("rsp_beat", 64'({(to_dc ? dc_resp_last : ic_resp_last), resp_data}),
                      64'(exp_beat));
            end
        end
    endtask

    initial begin
        int idx, stall, pulses, guard;
        bit exp_dc;
        reset = 1'b1;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
        dc_wdata_valid = 0; dc_wdata = '0;
        mem_req_ready = 0; mem_wdata_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        step(); step();
        check("rst_flags", 64'({busy, owner, err_unexp, mem_req_valid, ic_resp_valid, dc_resp_valid}), 64'd0);
        reset = 1'b0;
        step();

        // I-side line read, unaligned address
        ic_req_valid = 1'b1; ic_req_addr = 32'h2004;
        #1;
        check("ic_grant", 64'({ic_req_ready, dc_req_ready}), 64'd2);
        step();
        ic_req_valid = 1'b0;
        cmd_phase(32'h2000, 1'b0);
        check("ic_busy", 64'(busy), 64'd1);
        read_beats(1'b0, 32'hA000_0000, LB);
        #1;
        check("ic_done_busy", 64'(busy), 64'd1);
        step();
        check("ic_idle", 64'({busy, ic_resp_valid}), 64'd0);

        // D-side line write with a three-cycle memory stall on beat 2
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 32'h1000;
        #1;
        check("dc_wr_grant", 64'({ic_req_ready, dc_req_ready}), 64'd1);
        step();
        dc_req_valid = 1'b0;
        cmd_phase(32'h1000, 1'b1);
        for (int i = 0; i < LB; i++) wr_q.push_back(DW'(i + 1));
        idx = 0; stall = 0; pulses = 0; guard = 0;
        while (idx < LB && guard < 30) begin
            dc_wdata_valid  = 1'b1;
            dc_wdata        = DW'(idx + 1);
            mem_wdata_ready = !(idx == 1 && stall < 3);
            if (idx == 1 && stall < 3) stall++;
            #1;
            check("wr_ready_pass", 64'(dc_wdata_ready), 64'(mem_wdata_ready));
            if (mem_wdata_valid && mem_wdata_ready) begin
                check("wr_beat", 64'(mem_wdata), 64'(wr_q.pop_front()));
                idx++;
            end
            if (dc_wr_done) pulses++;
            step();
            guard++;
        end
        dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0;
        check("wr_beats", 64'(idx), 64'(LB));
        check("wr_cycles", 64'(guard), 64'(LB + 3));
        check("wr_early_done", 64'(pulses), 64'd0);
        #1;
        check("wr_done", 64'({dc_wr_done, busy}), 64'd3);
        step();
        check("wr_done_clear", 64'({dc_wr_done, busy}), 64'd0);

        // Simultaneous requests, D-side drops after acceptance, I-side holds
        ic_req_valid = 1'b1; ic_req_addr = 32'h4044;
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 32'h3008;
        #1;
        exp_dc = RR ? !owner : 1'b1;
        check("tie_grant", 64'({ic_req_ready, dc_req_ready}), exp_dc ? 64'd1 : 64'd2);
        step();
        if (exp_dc) begin
            dc_req_valid = 1'b0;
            #1;
            check("busy_no_grant", 64'({ic_req_ready, owner}), 64'd1);
            cmd_phase(32'h3000, 1'b0);
            read_beats(1'b1, 32'hD000_0000, LB);
            #1;
            check("done_no_grant", 64'({ic_req_ready, busy}), 64'd1);
            step();
            check("ic_after_done", 64'(ic_req_ready), 64'd1);
            step();
            ic_req_valid = 1'b0;
            cmd_phase(32'h4040, 1'b0);
            read_beats(1'b0, 32'hC000_0000, LB);
            step();
        end else begin
            ic_req_valid = 1'b0;
            cmd_phase(32'h4040, 1'b0);
            read_beats(1'b0, 32'hC000_0000, LB);
            #1;
            check("done_no_grant", 64'({dc_req_ready, busy}), 64'd1);
            step();
            check("dc_after_done", 64'(dc_req_ready), 64'd1);
            step();
            dc_req_valid = 1'b0;
            cmd_phase(32'h3000, 1'b0);
            read_beats(1'b1, 32'hD000_0000, LB);
            step();
        end
        check("tie_idle", 64'(busy), 64'd0);

        // Unexpected memory beat while idle
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("unexp_flag", 64'({err_unexp, ic_resp_valid, dc_resp_valid}), 64'd4);
        step();
        check("unexp_sticky", 64'({err_unexp, ic_resp_valid, dc_resp_valid, busy}), 64'd8);

        // Reset in the middle of a read burst
        ic_req_valid = 1'b1; ic_req_addr = 32'h2040;
        step();
        ic_req_valid = 1'b0;
        cmd_phase(32'h2040, 1'b0);
        read_beats(1'b0, 32'hB000_0000, 2);
        reset = 1'b1;
        #1;
        check("rst_mid_ctl", 64'({ic_req_ready, ic_resp_valid, ic_resp_last, dc_req_ready,
                                   dc_wdata_ready, dc_resp_valid, dc_resp_last, dc_wr_done,
                                   mem_req_valid, mem_req_rw, mem_wdata_valid, owner, busy,
                                   err_unexp}), 64'd0);
        check("rst_mid_data", 64'({resp_data, mem_req_addr}), 64'd0);
        check("rst_mid_wdata", 64'(mem_wdata), 64'd0);
        step();
        reset = 1'b0;
        step();
        ic_req_valid = 1'b1; ic_req_addr = 32'h2088;
        #1;
        check("fresh_grant", 64'(ic_req_ready), 64'd1);
        step();
        ic_req_valid = 1'b0;
        cmd_phase(32'h2080, 1'b0);
        read_beats(1'b0, 32'hE000_0000, LB);
        step();
        check("fresh_idle", 64'({busy, err_unexp}), 64'd0);

        // Both sides request continuously for four transactions, from reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ic_req_valid = 1'b1; ic_req_addr = 32'h5000;
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 32'h6010;
        for (int t = 0; t < 4; t++) begin
            #1;
            exp_dc = RR ? (t % 2 == 0) : 1'b1;
            check("cont_grant", 64'({ic_req_ready, dc_req_ready}), exp_dc ? 64'd1 : 64'd2);
            step();
            check("cont_owner", 64'(owner), 64'(exp_dc));
            cmd_phase(exp_dc ? 32'h6010 : 32'h5000, 1'b0);
            read_beats(exp_dc, 32'h1000_0000 * (t + 1), LB);
            #1;
            check("cont_done_hold", 64'({ic_req_ready, dc_req_ready}), 64'd0);
            step();
        end
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        check("sb_empty", 64'(rd_q.size() + wr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
